// File: rtl/padded_row_streamer.sv
// padded_row_streamer
// Writer side of the serial window-buffer interface. Takes one binary feature-map
// row per handshake and emits the zero-padded frame (top pad row, framed data rows,
// bottom pad row) as a 1-bit stream with a valid/ready style transfer qualifier.
// Every output is a flop; the next-output logic is derived from the next state so
// there is no combinational path from any input to any output.

module padded_row_streamer #(
   parameter int unsigned p_n_data_cols = 32,
   parameter int unsigned p_n_data_rows = 32,
   parameter logic        p_pad_val     = 1'b0,
   parameter int unsigned p_n_cols      = p_n_data_cols + 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [p_n_data_cols-1:0] row_in,
   input  logic                     row_in_valid,
   output logic                     row_in_ready,
   input  logic                     stream_ready,
   output logic                     stream_out,
   output logic                     stream_out_en,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int unsigned lp_col_w = (p_n_cols > 1) ? $clog2(p_n_cols) : 1;
   localparam int unsigned lp_row_w = (p_n_data_rows > 1) ? $clog2(p_n_data_rows) : 1;

   localparam logic [lp_col_w-1:0] lp_last_col = lp_col_w'(p_n_cols - 1);
   localparam logic [lp_row_w-1:0] lp_last_row = lp_row_w'(p_n_data_rows - 1);
   localparam logic [lp_col_w-1:0] lp_col_one  = lp_col_w'(1);
   localparam logic [lp_row_w-1:0] lp_row_one  = lp_row_w'(1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PAD_TOP  = 3'd1,
      ST_WAIT_ROW = 3'd2,
      ST_SEND_ROW = 3'd3,
      ST_PAD_BOT  = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   // Registered state
   state_t                   state_r;
   logic [lp_col_w-1:0]      col_cnt_r;
   logic [lp_row_w-1:0]      row_cnt_r;
   logic [p_n_data_cols-1:0] row_r;

   // Registered outputs
   logic                     row_in_ready_r;
   logic                     stream_out_r;
   logic                     stream_out_en_r;
   logic                     busy_r;
   logic                     frame_done_r;

   // Next-state / next-output terms
   state_t                   state_nxt_s;
   logic [lp_col_w-1:0]      col_cnt_nxt_s;
   logic [lp_row_w-1:0]      row_cnt_nxt_s;
   logic [p_n_data_cols-1:0] row_nxt_s;
   logic                     xfer_s;
   logic                     last_col_s;
   logic                     emit_nxt_s;
   logic [lp_col_w-1:0]      data_idx_s;
   logic [p_n_data_cols-1:0] row_shift_s;
   logic                     stream_out_nxt_s;

   assign row_in_ready  = row_in_ready_r;
   assign stream_out    = stream_out_r;
   assign stream_out_en = stream_out_en_r;
   assign busy          = busy_r;
   assign frame_done    = frame_done_r;

   // A bit moves only while the registered enable is up and the consumer accepts it.
   assign xfer_s     = stream_out_en_r & stream_ready;
   assign last_col_s = (col_cnt_r == lp_last_col);

   // Frame sequencing: next state, column/row counters and the latched data row.
   always_comb begin
      state_nxt_s   = state_r;
      col_cnt_nxt_s = col_cnt_r;
      row_cnt_nxt_s = row_cnt_r;
      row_nxt_s     = row_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_PAD_TOP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_PAD_TOP: begin
            if (xfer_s && last_col_s) begin
               col_cnt_nxt_s = '0;
               state_nxt_s   = ST_WAIT_ROW;
            end else if (xfer_s) begin
               col_cnt_nxt_s = col_cnt_r + lp_col_one;
            end else begin
               col_cnt_nxt_s = col_cnt_r;
            end
         end
         ST_WAIT_ROW: begin
            if (row_in_valid && row_in_ready_r) begin
               row_nxt_s   = row_in;
               state_nxt_s = ST_SEND_ROW;
            end else begin
               row_nxt_s   = row_r;
            end
         end
         ST_SEND_ROW: begin
            if (xfer_s && last_col_s) begin
               col_cnt_nxt_s = '0;
               if (row_cnt_r == lp_last_row) begin
                  row_cnt_nxt_s = '0;
                  state_nxt_s   = ST_PAD_BOT;
               end else begin
                  row_cnt_nxt_s = row_cnt_r + lp_row_one;
                  state_nxt_s   = ST_WAIT_ROW;
               end
            end else if (xfer_s) begin
               col_cnt_nxt_s = col_cnt_r + lp_col_one;
            end else begin
               col_cnt_nxt_s = col_cnt_r;
            end
         end
         ST_PAD_BOT: begin
            if (xfer_s && last_col_s) begin
               col_cnt_nxt_s = '0;
               state_nxt_s   = ST_DONE;
            end else if (xfer_s) begin
               col_cnt_nxt_s = col_cnt_r + lp_col_one;
            end else begin
               col_cnt_nxt_s = col_cnt_r;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            col_cnt_nxt_s = '0;
            row_cnt_nxt_s = '0;
            row_nxt_s     = '0;
         end
      endcase
   end

   // Stream bit for the next cycle: data columns pick the latched row bit, everything else is pad.
   always_comb begin
      emit_nxt_s  = (state_nxt_s == ST_PAD_TOP) || (state_nxt_s == ST_SEND_ROW) ||
                    (state_nxt_s == ST_PAD_BOT);
      data_idx_s  = col_cnt_nxt_s - lp_col_one;
      row_shift_s = row_nxt_s >> data_idx_s;
      if ((state_nxt_s == ST_SEND_ROW) && (col_cnt_nxt_s != '0) &&
          (col_cnt_nxt_s != lp_last_col)) begin
         stream_out_nxt_s = row_shift_s[0];
      end else begin
         stream_out_nxt_s = p_pad_val;
      end
   end

   // State, counters, row latch and all outputs; reset clears everything at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r         <= ST_IDLE;
         col_cnt_r       <= '0;
         row_cnt_r       <= '0;
         row_r           <= '0;
         row_in_ready_r  <= 1'b0;
         stream_out_r    <= 1'b0;
         stream_out_en_r <= 1'b0;
         busy_r          <= 1'b0;
         frame_done_r    <= 1'b0;
      end else begin
         state_r         <= state_nxt_s;
         col_cnt_r       <= col_cnt_nxt_s;
         row_cnt_r       <= row_cnt_nxt_s;
         row_r           <= row_nxt_s;
         row_in_ready_r  <= (state_nxt_s == ST_WAIT_ROW);
         stream_out_r    <= stream_out_nxt_s;
         stream_out_en_r <= emit_nxt_s;
         busy_r          <= (state_nxt_s != ST_IDLE);
         frame_done_r    <= (state_nxt_s == ST_DONE);
      end
   end

endmodule

// File: tb/tb_padded_row_streamer.sv
// Self-checking bench for padded_row_streamer: the stimulus pushes the golden padded
// frame into a scoreboard queue; an independent monitor pops one bit per transfer.

module tb_padded_row_streamer;

   localparam int NC          = 32;
   localparam int NR          = 32;
   localparam int NCOLS       = NC + 2;
   localparam int FRAME_BITS  = (NR + 2) * NCOLS;   // 1156
   // 1190 cycles counted inclusively (start cycle .. pulse cycle) is 1188 edges
   // between the edge sampling start and the edge raising frame_done.
   localparam int FRAME_EDGES = 1190 - 2;

   logic          clk;
   logic          reset;
   logic          start;
   logic [NC-1:0] row_in;
   logic          row_in_valid;
   logic          row_in_ready;
   logic          stream_ready;
   logic          stream_out;
   logic          stream_out_en;
   logic          busy;
   logic          frame_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int xfer_cnt = 0;
   int frame_base = 0;
   int done_samples = 0;
   int done_cyc = 0;
   int start_cyc = 0;
   bit rdy_toggle = 1'b0;
   bit hold_pending = 1'b0;
   logic hold_bit;
   bit exp_q[$];
   logic got_bits [0:FRAME_BITS-1];
   logic [NC-1:0] rows [0:NR-1];
   bit aborted;

   padded_row_streamer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .row_in       (row_in),
      .row_in_valid (row_in_valid),
      .row_in_ready (row_in_ready),
      .stream_ready (stream_ready),
      .stream_out   (stream_out),
      .stream_out_en(stream_out_en),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_int(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Monitor: scoreboard pop per transfer, hold-while-stalled, frame_done pulse capture.
   initial begin
      bit e;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (hold_pending) begin
               check_bit("hold_en", stream_out_en, 1'b1);
               check_bit("hold_bit", stream_out, hold_bit);
            end
            if (frame_done) begin
               done_samples++;
               done_cyc = cyc;
            end
            if (stream_out_en) check_bit("busy_with_en", busy, 1'b1);
            if (stream_out_en && stream_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL stream_extra: transfer %0d with empty scoreboard", xfer_cnt - frame_base);
               end else begin
                  e = exp_q.pop_front();
                  check_bit($sformatf("stream_bit[%0d]", xfer_cnt - frame_base), stream_out, e);
               end
               if ((xfer_cnt - frame_base) >= 0 && (xfer_cnt - frame_base) < FRAME_BITS)
                  got_bits[xfer_cnt - frame_base] = stream_out;
               xfer_cnt++;
            end
            hold_pending = stream_out_en && !stream_ready;
            hold_bit     = stream_out;
         end else begin
            hold_pending = 1'b0;
         end
      end
   end

   // Consumer readiness: constant 1, or toggling every cycle when requested.
   initial begin
      stream_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_toggle) stream_ready = ~stream_ready;
         else            stream_ready = 1'b1;
      end
   end

   // Golden padded frame: pad ring around the rows, row bit 0 is the leftmost data column.
   task automatic push_frame();
      for (int fr = 0; fr < NR + 2; fr++) begin
         for (int c = 0; c < NCOLS; c++) begin
            if (fr == 0 || fr == NR + 1 || c == 0 || c == NCOLS - 1) exp_q.push_back(1'b0);
            else exp_q.push_back(rows[fr-1][c-1]);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int abort_at, input int glitch_row, input int stall_row,
                            input bit check_lat, output bit was_aborted);
      int wait_cnt;
      was_aborted = 1'b0;
      exp_q.delete();
      push_frame();
      frame_base   = xfer_cnt;
      done_samples = 0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      start_cyc = cyc;
      check_bit("busy_after_start", busy, 1'b1);
      for (int r = 0; r < NR; r++) begin
         wait_cnt = 0;
         while (!row_in_ready) begin
            if (abort_at >= 0 && (xfer_cnt - frame_base) == abort_at) begin
               reset = 1'b0;
               #1;
               check_bit("rst_en", stream_out_en, 1'b0);
               check_bit("rst_out", stream_out, 1'b0);
               check_bit("rst_ready", row_in_ready, 1'b0);
               check_bit("rst_busy", busy, 1'b0);
               check_bit("rst_done", frame_done, 1'b0);
               exp_q.delete();
               repeat (3) step();
               check_int("rst_no_frame_done", done_samples, 0);
               reset = 1'b1;
               step();
               was_aborted = 1'b1;
               return;
            end
            if (wait_cnt > 200) begin
               checks++;
               errors++;
               $display("FAIL row_ready_timeout: row %0d never became ready", r);
               return;
            end
            step();
            wait_cnt++;
         end
         if (r == stall_row) begin
            for (int k = 0; k < 10; k++) begin
               check_bit("stall_ready", row_in_ready, 1'b1);
               check_bit("stall_en", stream_out_en, 1'b0);
               step();
            end
         end
         row_in       = rows[r];
         row_in_valid = 1'b1;
         step();
         row_in_valid = 1'b0;
         row_in       = 32'hDEAD_BEEF;
         if (r == glitch_row) begin
            start = 1'b1;
            step();
            start = 1'b0;
            check_bit("glitch_busy", busy, 1'b1);
         end
      end
      wait_cnt = 0;
      while (done_samples == 0 && wait_cnt < 2000) begin
         step();
         wait_cnt++;
      end
      check_int("frame_done_seen", done_samples, 1);
      if (check_lat) check_int("frame_latency", done_cyc - start_cyc, FRAME_EDGES);
      repeat (3) step();
      check_int("frame_done_pulses", done_samples, 1);
      check_bit("idle_busy", busy, 1'b0);
      check_int("scoreboard_empty", exp_q.size(), 0);
      check_int("transfer_count", xfer_cnt - frame_base, FRAME_BITS);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      logic [NC-1:0] v;
      reset        = 1'b1;
      start        = 1'b0;
      row_in       = 32'hDEAD_BEEF;
      row_in_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check_bit("reset_en", stream_out_en, 1'b0);
      check_bit("reset_out", stream_out, 1'b0);
      check_bit("reset_ready", row_in_ready, 1'b0);
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_done", frame_done, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      step();

      // T1: all-ones rows, full-rate handshake and stream
      for (int r = 0; r < NR; r++) rows[r] = 32'hFFFF_FFFF;
      run_frame(-1, -1, -1, 1'b1, aborted);
      check_bit("t1_bit34", got_bits[34], 1'b0);
      check_bit("t1_bit35", got_bits[35], 1'b1);
      check_bit("t1_bit66", got_bits[66], 1'b1);
      check_bit("t1_bit67", got_bits[67], 1'b0);
      check_bit("t1_bit68", got_bits[68], 1'b0);
      check_bit("t1_bit1155", got_bits[1155], 1'b0);

      // T2: single patterned row, order check LSB first
      for (int r = 0; r < NR; r++) rows[r] = 32'h0000_0000;
      rows[0] = 32'hA5A5_0F0F;
      run_frame(-1, -1, -1, 1'b1, aborted);
      for (int i = 0; i < NC; i++) v[i] = got_bits[35 + i];
      check_int("t2_row0_bits", v, 32'hA5A5_0F0F);
      check_bit("t2_bit34", got_bits[34], 1'b0);
      check_bit("t2_bit67", got_bits[67], 1'b0);

      // T3: consumer ready toggling every cycle
      for (int r = 0; r < NR; r++) rows[r] = 32'hFFFF_FFFF;
      rdy_toggle = 1'b1;
      run_frame(-1, -1, -1, 1'b0, aborted);
      rdy_toggle = 1'b0;
      step();

      // T4: row 3 supplier stall for 10 cycles
      for (int r = 0; r < NR; r++) rows[r] = 32'h9E37_79B9 * (r + 1);
      run_frame(-1, -1, 3, 1'b0, aborted);

      // T5: reset at row 5 col 17, then a fresh frame with different rows
      run_frame(NCOLS + 5 * NCOLS + 17, -1, -1, 1'b0, aborted);
      check_bit("t5_aborted", aborted, 1'b1);
      for (int r = 0; r < NR; r++) rows[r] = 32'h0F1E_2D3C ^ (32'h0101_0101 * r);
      run_frame(-1, -1, -1, 1'b1, aborted);

      // T6: start pulse during SEND_ROW is ignored
      for (int r = 0; r < NR; r++) rows[r] = 32'hC3A5_5A3C + r;
      run_frame(-1, 2, -1, 1'b0, aborted);
      repeat (5) step();
      check_bit("t6_no_restart", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
